// File: rtl/tcb_pkg.sv
// Shared TCB types: handshake/bus/packing configs, request/response payloads and defaults.
// Bus payload widths are fixed here; controllers check their BUS parameter against them.
package tcb_pkg;

    typedef enum logic {HALF_DUPLEX = 1'b0, FULL_DUPLEX = 1'b1} tcb_chn_t;
    typedef enum logic {LOG_SIZE = 1'b0, BYTE_ENA = 1'b1} tcb_mod_t;
    typedef enum logic {DESCENDING = 1'b0, ASCENDING = 1'b1} tcb_ord_t;
    typedef enum logic [1:0] {BI_NDN = 2'd0, LITTLE = 2'd1, BIG = 2'd2} tcb_ndn_t;

    typedef struct packed {
        int unsigned DLY;
    } tcb_hsk_t;

    typedef struct packed {
        int unsigned ADR;
        int unsigned DAT;
        tcb_chn_t    CHN;
        tcb_mod_t    MOD;
        tcb_ord_t    ORD;
        tcb_ndn_t    NDN;
    } tcb_bus_t;

    typedef struct packed {
        int unsigned MIN;
        int unsigned OFF;
        int unsigned ALN;
        int unsigned BND;
    } tcb_pck_t;

    localparam int unsigned TCB_ADR = 32;
    localparam int unsigned TCB_DAT = 32;
    localparam int unsigned TCB_BEN = TCB_DAT / 8;

    localparam tcb_hsk_t TCB_HSK_DEF = '{DLY: 1};
    localparam tcb_bus_t TCB_BUS_DEF = '{ADR: TCB_ADR, DAT: TCB_DAT, CHN: HALF_DUPLEX,
                                         MOD: BYTE_ENA, ORD: DESCENDING, NDN: BI_NDN};
    localparam tcb_pck_t TCB_PCK_DEF = '{MIN: 0, OFF: 0, ALN: 0, BND: 0};

    typedef struct packed {
        logic err;
    } tcb_rsp_sts_t;

    typedef struct packed {
        logic               wen;
        logic               ndn;
        logic [TCB_ADR-1:0] adr;
        logic [TCB_BEN-1:0] ben;
        logic [TCB_DAT-1:0] wdt;
    } tcb_req_t;

    typedef struct packed {
        logic [TCB_DAT-1:0] rdt;
        tcb_rsp_sts_t       sts;
    } tcb_rsp_t;

endpackage

// File: rtl/tcb_if.sv
// TCB point-to-point link: request valid/ready plus request and response payloads.
// Clock and synchronous reset travel with the link so both ends share them.
interface tcb_if (
    input logic clk,
    input logic rst
);
    import tcb_pkg::*;

    logic     vld;
    logic     rdy;
    tcb_req_t req;
    tcb_rsp_t rsp;

    modport man (input clk, input rst, output vld, output req, input rdy, input rsp);
    modport sub (input clk, input rst, input vld, input req, output rdy, output rsp);

endinterface

// File: rtl/tcb_lib_delay_pipe.sv
// Generic register delay line of DLY stages (DLY=0 is a wire).
// Latency DLY cycles; no backpressure, every stage advances each cycle; stages clear on rst.
module tcb_lib_delay_pipe #(
    parameter int WIDTH = 1,
    parameter int DLY   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DLY == 0) begin : g_bypass
            logic unused_ctl;
            assign unused_ctl = clk | rst;
            assign dout       = din;
        end else begin : g_pipe
            logic [DLY-1:0][WIDTH-1:0] stg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    stg <= '0;
                end else begin
                    stg[0] <= din;
                    for (int s = 1; s < DLY; s++) begin
                        stg[s] <= stg[s-1];
                    end
                end
            end

            assign dout = stg[DLY-1];
        end
    endgenerate

endmodule

// File: rtl/tcb_lib_misaligned_sram_controller.sv
// Maps a byte-enable TCB bus onto independent SRAM banks so misaligned accesses finish in one transfer.
// Latency HSK.DLY cycles request->response; always ready, one transfer per cycle, no backpressure.
module tcb_lib_misaligned_sram_controller
    import tcb_pkg::*;
#(
    parameter  tcb_hsk_t HSK     = TCB_HSK_DEF,
    parameter  tcb_bus_t BUS     = TCB_BUS_DEF,
    parameter  tcb_pck_t PCK     = TCB_PCK_DEF,
    localparam int       BUS_BEN = int'(BUS.DAT / 8),
    localparam int       BUS_MAX = $clog2(BUS_BEN),
    localparam int       MEM_CEN = BUS_BEN >> PCK.OFF,
    localparam int       MEM_ADR = int'(BUS.ADR) - BUS_MAX,
    localparam int       MEM_DAT = int'(BUS.DAT) / MEM_CEN
) (
    tcb_if.sub                               tcb,
    output logic [MEM_CEN-1:0]               mem_cen,
    output logic                             mem_wen,
    output logic [MEM_CEN-1:0][MEM_ADR-1:0]  mem_adr,
    output logic [MEM_CEN-1:0][MEM_DAT-1:0]  mem_wdt,
    input  logic [MEM_CEN-1:0][MEM_DAT-1:0]  mem_rdt
);

    localparam int BNK_BEN = 2 ** PCK.OFF;

    generate
        if (HSK.DLY == 0) begin : g_err_dly
            $error("response delay DLY must be at least 1");
        end
        if (BUS.MOD != BYTE_ENA) begin : g_err_mod
            $error("only byte-enable bus mode is supported");
        end
        if (BUS.CHN != HALF_DUPLEX) begin : g_err_chn
            $error("only half-duplex channel is supported");
        end
        if (BUS.ADR != TCB_ADR || BUS.DAT != TCB_DAT) begin : g_err_width
            $error("BUS widths must match the tcb_if payload widths");
        end
    endgenerate

    logic               req_act;
    logic [MEM_ADR-1:0] wa;
    logic [BUS_MAX-1:0] bank_off;
    logic [BUS.DAT-1:0] rdt_mem;
    logic               rd_q;
    tcb_rsp_t           rsp_d;
    logic [$bits(tcb_rsp_t)-1:0] rsp_q;
    logic               unused_ndn;

    assign tcb.rdy    = 1'b1;
    assign unused_ndn = tcb.req.ndn;

    // A request seen during reset never reaches the banks.
    assign req_act  = tcb.vld & ~tcb.rst;
    assign mem_wen  = req_act & tcb.req.wen;
    assign wa       = tcb.req.adr[BUS.ADR-1:BUS_MAX];
    assign bank_off = tcb.req.adr[BUS_MAX-1:0] >> PCK.OFF;

    // Banks below the start offset hold the wrapped upper bytes, so they address the next word.
    for (genvar i = 0; i < MEM_CEN; i++) begin : g_bank
        localparam logic [BUS_MAX-1:0] BANK_IDX = BUS_MAX'(i);

        assign mem_adr[i] = wa + MEM_ADR'(BANK_IDX < bank_off);
        assign mem_cen[i] = req_act & (|tcb.req.ben[i*BNK_BEN +: BNK_BEN]);
        assign mem_wdt[i] = tcb.req.wdt[i*MEM_DAT +: MEM_DAT];
        assign rdt_mem[i*MEM_DAT +: MEM_DAT] = mem_rdt[i];

        if (PCK.OFF > 0) begin : g_ben_chk
            always_ff @(posedge tcb.clk) begin
                if (!tcb.rst && tcb.vld) begin
                    assert ((&tcb.req.ben[i*BNK_BEN +: BNK_BEN]) || !(|tcb.req.ben[i*BNK_BEN +: BNK_BEN]))
                        else $error("partial byte enable within a bank");
                end
            end
        end
    end

    // Tracks whether the SRAM output this cycle belongs to a read, so idle/reset rdt stays 0.
    always_ff @(posedge tcb.clk) begin
        if (tcb.rst) begin
            rd_q <= 1'b0;
        end else begin
            rd_q <= req_act & ~tcb.req.wen;
        end
    end

    always_comb begin
        rsp_d         = '0;
        rsp_d.rdt     = rd_q ? rdt_mem : '0;
        rsp_d.sts.err = 1'b0;
    end

    tcb_lib_delay_pipe #(
        .WIDTH ($bits(tcb_rsp_t)),
        .DLY   (int'(HSK.DLY) - 1)
    ) u_rsp_dly (
        .clk  (tcb.clk),
        .rst  (tcb.rst),
        .din  (rsp_d),
        .dout (rsp_q)
    );

    assign tcb.rsp = rsp_q;

endmodule

// File: tb/tb_tcb_lib_misaligned_sram_controller.sv
// Bench: drives TCB transfers against a 4-bank byte SRAM model; a scoreboard checks rdt/sts DLY cycles later.
module tb_tcb_lib_misaligned_sram_controller;
    import tcb_pkg::*;

    localparam int DLY = int'(TCB_HSK_DEF.DLY);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tcb_if bus (.clk(clk), .rst(rst));

    logic [3:0]       mem_cen;
    logic             mem_wen;
    logic [3:0][29:0] mem_adr;
    logic [3:0][7:0]  mem_wdt;
    logic [3:0][7:0]  mem_rdt;

    tcb_lib_misaligned_sram_controller dut (
        .tcb     (bus),
        .mem_cen (mem_cen),
        .mem_wen (mem_wen),
        .mem_adr (mem_adr),
        .mem_wdt (mem_wdt),
        .mem_rdt (mem_rdt)
    );

    // Single-port synchronous byte-wide banks, 1-cycle read latency.
    logic [7:0] sram [4][256];
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_cen[i]) begin
                if (mem_wen) sram[i][mem_adr[i][7:0]] <= mem_wdt[i];
                else         mem_rdt[i] <= sram[i][mem_adr[i][7:0]];
            end
        end
    end

    typedef struct {
        int          due;
        logic [31:0] rdt;
        logic [31:0] msk;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, "_due"}, 64'(e.due), 64'(cyc));
            if (e.msk != 0) chk({e.tag, "_rdt"}, 64'(bus.rsp.rdt & e.msk), 64'(e.rdt & e.msk));
            chk({e.tag, "_sts"}, 64'(bus.rsp.sts), 64'(0));
        end
    end

    // Byte b of dat goes to lane (adr+b) mod 4; read expectations are placed the same way.
    task automatic xfer(input bit wen, input logic [31:0] adr, input int siz,
                        input logic [31:0] dat, input string tag);
        exp_t        e;
        logic [3:0]  ben = '0;
        logic [31:0] lane_dat = '0;
        logic [31:0] msk = '0;
        for (int b = 0; b < (1 << siz); b++) begin
            int l;
            l = int'((adr + 32'(b)) % 4);
            ben[l]            = 1'b1;
            lane_dat[l*8 +: 8] = dat[b*8 +: 8];
            msk[l*8 +: 8]      = 8'hff;
        end
        @(posedge clk); #1;
        bus.vld     = 1'b1;
        bus.req.wen = wen;
        bus.req.ndn = 1'b0;
        bus.req.adr = adr;
        bus.req.ben = ben;
        bus.req.wdt = wen ? lane_dat : $urandom;
        e.due = cyc + DLY;
        e.rdt = lane_dat;
        e.msk = wen ? 32'h0 : msk;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        bus.vld = 1'b0;
    endtask

    logic [31:0] mis_adr [3] = '{32'hb1, 32'hc2, 32'hd3};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst     = 1'b1;
        bus.vld = 1'b1;
        bus.req = '0;
        bus.req.wen = 1'b1;
        bus.req.ben = 4'hf;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cen", 64'(mem_cen), 64'(0));
        chk("rst_wen", 64'(mem_wen), 64'(0));
        chk("rst_rdt", 64'(bus.rsp.rdt), 64'(0));
        chk("rst_sts", 64'(bus.rsp.sts), 64'(0));
        chk("rst_rdy", 64'(bus.rdy), 64'(1));
        @(posedge clk); #1;
        rst     = 1'b0;
        bus.vld = 1'b0;
        @(negedge clk);
        chk("idle_cen", 64'(mem_cen), 64'(0));

        // Aligned writes and reads
        xfer(1, 32'h10, 0, 32'h10, "w8_10");
        xfer(1, 32'h11, 0, 32'h32, "w8_11");
        xfer(1, 32'h12, 0, 32'h54, "w8_12");
        xfer(1, 32'h13, 0, 32'h76, "w8_13");
        xfer(1, 32'h20, 1, 32'hba98, "w16_20");
        xfer(1, 32'h22, 1, 32'hfedc, "w16_22");
        xfer(1, 32'h30, 2, 32'h76543210, "w32_30");
        xfer(0, 32'h10, 2, 32'h76543210, "r32_10");
        xfer(0, 32'h20, 2, 32'hfedcba98, "r32_20");
        xfer(0, 32'h12, 0, 32'h54, "r8_12");
        xfer(0, 32'h30, 2, 32'h76543210, "r32_30");

        // Misaligned 16-bit, inside one word and wrapping into the next
        xfer(1, 32'h91, 1, 32'h3210, "w16_91");
        xfer(0, 32'h91, 1, 32'h3210, "r16_91");
        chk("bank1_24", 64'(sram[1][8'h24]), 64'h10);
        chk("bank2_24", 64'(sram[2][8'h24]), 64'h32);
        xfer(1, 32'ha3, 1, 32'h7654, "w16_a3");
        xfer(0, 32'ha3, 1, 32'h7654, "r16_a3");
        chk("bank3_28", 64'(sram[3][8'h28]), 64'h54);
        chk("bank0_29", 64'(sram[0][8'h29]), 64'h76);

        // Misaligned 32-bit
        foreach (mis_adr[k]) begin
            xfer(1, mis_adr[k], 2, 32'h76543210, $sformatf("w32_%0h", mis_adr[k]));
            if (k == 2) begin
                #1;
                chk("d3_adr0", 64'(mem_adr[0]), 64'h35);
                chk("d3_adr1", 64'(mem_adr[1]), 64'h35);
                chk("d3_adr2", 64'(mem_adr[2]), 64'h35);
                chk("d3_adr3", 64'(mem_adr[3]), 64'h34);
                chk("d3_cen",  64'(mem_cen), 64'hf);
                chk("d3_wen",  64'(mem_wen), 64'h1);
            end
            xfer(0, mis_adr[k], 2, 32'h76543210, $sformatf("r32_%0h", mis_adr[k]));
        end

        // Size/offset sweep; the read right after the write also covers read-after-write
        for (int siz = 0; siz < 3; siz++) begin
            for (int off = 0; off < 4; off++) begin
                logic [31:0] d = '0;
                for (int b = 0; b < 4; b++) d[b*8 +: 8] = 8'(siz * 16 + off + b);
                xfer(1, 32'(siz * 8 + off), siz, d, $sformatf("sw_w_%0d_%0d", siz, off));
                xfer(0, 32'(siz * 8 + off), siz, d, $sformatf("sw_r_%0d_%0d", siz, off));
            end
        end

        // Top of address space: the upper byte wraps to word 0
        xfer(1, 32'hffff_ffff, 1, 32'hbeef, "w16_top");
        #1;
        chk("top_adr3", 64'(mem_adr[3]), 64'h3fff_ffff);
        chk("top_adr0", 64'(mem_adr[0]), 64'h0);
        chk("top_cen",  64'(mem_cen), 64'h9);
        xfer(0, 32'hffff_ffff, 1, 32'hbeef, "r16_top");

        // Reset while a read response is pending
        xfer(0, 32'h30, 2, 32'h76543210, "r32_pre_rst");
        begin
            exp_t e;
            @(posedge clk); #1;
            rst         = 1'b1;
            bus.vld     = 1'b1;
            bus.req.wen = 1'b0;
            bus.req.adr = 32'h20;
            bus.req.ben = 4'hf;
            e.due = cyc + DLY;
            e.rdt = 32'h0;
            e.msk = 32'hffff_ffff;
            e.tag = "rst_mid";
            sb.push_back(e);
            #1;
            chk("rst_mid_cen", 64'(mem_cen), 64'(0));
            @(posedge clk); #1;
            chk("rst_hold_cen", 64'(mem_cen), 64'(0));
            rst     = 1'b0;
            bus.vld = 1'b0;
        end

        idle();
        for (int n = 0; n < DLY + 4 && sb.size() > 0; n++) @(posedge clk);
        @(negedge clk);
        chk("drain", 64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tcb_lib_misaligned_sram_controller.md
Name: tcb_lib_misaligned_sram_controller

Overview:
- TCB subordinate that maps one TCB byte-enable bus onto MEM_CEN independent SRAM banks.
- Each bank has its own chip enable and address, so an access misaligned within the bus word completes in one transfer.
- Sits between a TCB manager (CPU load/store unit or VIP) and an array of single-port synchronous SRAMs with 1-cycle read latency.

Parameters:
- HSK, TCB_HSK_DEF (DLY=1): handshake config; DLY = response delay in cycles, must be >=1.
- BUS, TCB_BUS_DEF with CHN=HALF_DUPLEX, MOD=BYTE_ENA, ORD=DESCENDING, NDN=BI_NDN: ADR=32, DAT=32.
- PCK, '{MIN:0, OFF:0, ALN:0, BND:0}: packing config; OFF = log2 of bank width in bytes.
- Derived localparams:
  - BUS_BEN = DAT/8
  - BUS_MAX = clog2(BUS_BEN)
  - MEM_CEN = BUS_BEN/2**OFF
  - MEM_ADR = ADR-BUS_MAX
  - MEM_DAT = DAT/MEM_CEN

Ports:
- Clock and reset: one clock; reset is synchronous and active-high. Both are taken from the tcb_if instance as clk and rst.
- tcb (subordinate modport of tcb_if), carrying:
  - clk  in  1  clock
  - rst  in  1  synchronous active-high reset
  - tcb.vld  in  1  request valid
  - tcb.rdy  out  1  request ready
  - tcb.req.wen  in  1  1=write, 0=read (half duplex)
  - tcb.req.ndn  in  1  endianness (ignored; lanes already placed by manager)
  - tcb.req.adr  in  ADR  byte address
  - tcb.req.ben  in  BUS_BEN  byte enables
  - tcb.req.wdt  in  DAT  write data, byte lane k = address lane k
  - tcb.rsp.rdt  out  DAT  read data
  - tcb.rsp.sts  out  status  response status
- mem_cen  out  MEM_CEN  per-bank chip enable
- mem_wen  out  1  write enable, shared by all banks
- mem_adr  out  MEM_CEN x MEM_ADR  per-bank address
- mem_wdt  out  MEM_CEN x MEM_DAT  per-bank write data
- mem_rdt  in  MEM_CEN x MEM_DAT  per-bank read data, valid 1 cycle after cen

Behaviour:
- tcb.rdy is constant 1; a transfer occurs when tcb.vld=1.
- Lane convention: byte-enable mode puts the byte for address A on lane A mod BUS_BEN. A misaligned access wraps its upper bytes into low lanes. Bank i serves lanes [i*2**OFF +: 2**OFF]. Data needs no rotation.
- Combinational decode, with wa = adr[ADR-1:BUS_MAX] and off = adr[BUS_MAX-1:OFF]:
  - mem_adr[i] = wa + (i < off ? 1 : 0), modulo 2**MEM_ADR, so the top word wraps to 0.
  - mem_cen[i] = vld & OR(ben lanes of bank i).
  - mem_wen = vld & wen.
  - mem_wdt[i] = wdt lanes of bank i.
- Partial enables within a bank are illegal when OFF>0. Enforce with a simulation assertion.
- Read path:
  - mem_rdt[i] drives rdt lanes of bank i, one cycle after the request.
  - For DLY>1, rdt passes through DLY-1 additional register stages.
  - rdt lanes with ben=0 are don't-care.
- Write response: no data; rdt don't-care.
- sts = 0 for every transfer (no error generation), delayed DLY cycles, aligned with rdt.
- Back-to-back transfers are pipelined at one per cycle. Read-after-write to the same address on consecutive cycles returns the new data, as the SRAM model does.
- Reset:
  - Internal delay-pipeline registers clear on rst.
  - mem_cen=0 and mem_wen=0 whenever vld=0.
  - A request presented while rst=1 is dropped (cen gated by !rst).
  - rdt/sts after reset are 0.
- Elaboration error if DLY==0, MOD!=BYTE_ENA, or CHN!=HALF_DUPLEX.

Decomposition:
- tcb_pkg holds tcb_hsk_t, tcb_bus_t, tcb_pck_t, tcb_req_t, tcb_rsp_t, tcb_rsp_sts_t and the defaults.
- The controller is a single module.
- The DLY pipeline is natural as generic sub-module tcb_lib_delay_pipe (WIDTH, DLY, clk, rst).

Test Plan:
- Aligned writes:
  - write8 0x10=0x10, 0x11=0x32, 0x12=0x54, 0x13=0x76
  - write16 0x20=0xba98, 0x22=0xfedc
  - write32 0x30=0x76543210
  - Then read32 0x10 -> 0x76543210; 0x20 -> 0xfedcba98; read8 0x12 -> 0x54; sts=0 throughout.
- Misaligned 16-bit: write16 0x91=0x3210 -> banks 1,2 at word 0x24; read16 0x91 -> 0x3210.
- Misaligned 16-bit wrap: write16 0xa3=0x7654 -> bank3 word 0x28 = 0x54, bank0 word 0x29 = 0x76; read back 0x7654.
- Misaligned 32-bit: write32 at 0xb1, 0xc2 and 0xd3 = 0x76543210; each read32 at the same address -> 0x76543210 in DLY cycles. For 0xd3, mem_adr = {0x35, 0x35, 0x35, 0x34} for banks 0..3.
- Sweep:
  - For siz 0..2 and off 0..3, adr = siz*8 + off.
  - Write bytes {siz, off+i}, then read and compare, for all 12 combinations.
- Reset: assert rst mid-read -> rdt/sts clear to 0, no mem_cen asserted while rst=1.
